// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-hit window counter.
//   state_t       : window FSM encoding (IDLE=1'b0, RUN=1'b1)
//   DEF_WIN_LEN   : default window length in clk cycles
//   DEF_CNT_W     : default hit-count width
//   DEF_THRESH    : default alarm threshold
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_WIN_LEN = 64;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_THRESH  = 4;

endpackage

// File: rtl/seq_hit_window_counter_win_timer.sv
// win_timer: modulo-WIN_LEN cycle counter for the hit window.
// Counts RUN cycles 0..WIN_LEN-1 and flags the final cycle of each window.
// The position is held at zero whenever run is low, so a new window always
// starts from its first cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   run  : window FSM is in RUN this cycle
//   last : this RUN cycle is the final cycle of the window
module win_timer #(
  parameter int unsigned WIN_LEN = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic last
);

  localparam int unsigned PW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [PW-1:0] LAST_POS = PW'(WIN_LEN - 1);

  logic [PW-1:0] pos;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos <= '0;
    end else if (!run || pos == LAST_POS) begin
      pos <= '0;
    end else begin
      pos <= pos + 1'b1;
    end
  end

  assign last = run && (pos == LAST_POS);

endmodule

// File: rtl/seq_hit_window_counter.sv
// seq_hit_window_counter: counts hit pulses over fixed windows of WIN_LEN
// RUN cycles and presents each completed window's count through a
// valid/ready result register with overrun and threshold-alarm flags.
// Optional feature macro: SEQ_HIT_STICKY_ALARM_EN -- when defined, alarm
// stays high once set until reset or the FSM returns to IDLE.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-low reset
//   en          : window counting enable (IDLE <-> RUN)
//   hit         : one-cycle match pulse from the upstream detector
//   res_ready   : consumer accepts result
//   res_valid   : result available
//   res_count   : hits counted in last completed window (saturating)
//   res_overrun : an unread result was overwritten
//   alarm       : last completed window reached THRESH
//   win_active  : FSM in RUN
module seq_hit_window_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned WIN_LEN = DEF_WIN_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned THRESH  = DEF_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hit,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_count,
  output logic             res_overrun,
  output logic             alarm,
  output logic             win_active
);

  state_t           state, state_next;
  logic             run;
  logic             win_last;
  logic             done;
  logic             handshake;
  logic [CNT_W-1:0] live;
  logic [CNT_W-1:0] live_inc;
  logic             over;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    run        = 1'b0;
    case (state)
      IDLE: if (en) state_next = RUN;
      RUN: begin
        run = 1'b1;
        if (!en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign win_active = run;

  win_timer #(.WIN_LEN(WIN_LEN)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .last (win_last)
  );

  // Count including this cycle's hit, saturating at all-ones.
  assign live_inc  = (hit && live != '1) ? live + 1'b1 : live;
  assign done      = run && win_last;
  assign handshake = res_valid && res_ready;
  assign over      = (32'(live_inc) >= THRESH);

  // Live count is cleared in IDLE, which discards any partial window.
  always_ff @(posedge clk) begin
    if (!rst || !run || win_last) live <= '0;
    else                          live <= live_inc;
  end

  // A completion takes priority over a handshake: the new result is loaded,
  // valid stays high, and overrun only rises when the old result was unread.
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid   <= 1'b0;
      res_count   <= '0;
      res_overrun <= 1'b0;
    end else if (done) begin
      res_valid <= 1'b1;
      res_count <= live_inc;
      if (res_valid && !res_ready) res_overrun <= 1'b1;
    end else if (handshake) begin
      res_valid   <= 1'b0;
      res_overrun <= 1'b0;
    end
  end

`ifdef SEQ_HIT_STICKY_ALARM_EN
  always_ff @(posedge clk) begin
    if (!rst || !en)   alarm <= 1'b0;
    else if (done && over) alarm <= 1'b1;
  end
`else
  always_ff @(posedge clk) begin
    if (!rst)      alarm <= 1'b0;
    else if (done) alarm <= over;
  end
`endif

endmodule

// File: tb/tb_seq_hit_window_counter.sv
module tb_seq_hit_window_counter;

  localparam int unsigned WIN = 8;
  localparam int unsigned THR = 4;

  logic clk = 1'b0;
  logic rst, en, hit, res_ready;
  logic       v0, o0, a0, w0;
  logic [7:0] c0;
  logic       v1, o1, a1, w1;
  logic [1:0] c1;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  seq_hit_window_counter #(.WIN_LEN(WIN), .CNT_W(8), .THRESH(THR)) dut0 (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .res_ready(res_ready),
    .res_valid(v0), .res_count(c0), .res_overrun(o0), .alarm(a0), .win_active(w0));

  seq_hit_window_counter #(.WIN_LEN(WIN), .CNT_W(2), .THRESH(THR)) dut1 (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .res_ready(res_ready),
    .res_valid(v1), .res_count(c1), .res_overrun(o1), .alarm(a1), .win_active(w1));

  // Reference model: window position in RUN cycles, per-instance live
  // count and result registers, updated once per clock edge.
  bit          m_run;
  int unsigned m_pos;
  int unsigned m_live [2];
  int unsigned m_cnt  [2];
  bit          m_valid[2];
  bit          m_ovr  [2];
  bit          m_alarm[2];
  int unsigned m_max  [2] = '{255, 3};

  task automatic model_edge(input bit r, input bit e, input bit h, input bit rd);
    bit done;
    int unsigned tot;
    if (!r) begin
      m_run = 0; m_pos = 0;
      for (int unsigned i = 0; i < 2; i++) begin
        m_live[i] = 0; m_cnt[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_alarm[i] = 0;
      end
      return;
    end
    done = m_run && (m_pos == WIN - 1);
    for (int unsigned i = 0; i < 2; i++) begin
      tot = m_run ? m_live[i] + h : 0;
      if (tot > m_max[i]) tot = m_max[i];
      if (done) begin
        if (m_valid[i] && !rd) m_ovr[i] = 1;
        m_valid[i] = 1;
        m_cnt[i]   = tot;
`ifdef SEQ_HIT_STICKY_ALARM_EN
        if (tot >= THR) m_alarm[i] = 1;
`else
        m_alarm[i] = (tot >= THR);
`endif
      end else if (m_valid[i] && rd) begin
        m_valid[i] = 0;
        m_ovr[i]   = 0;
      end
`ifdef SEQ_HIT_STICKY_ALARM_EN
      if (!e) m_alarm[i] = 0;
`endif
      m_live[i] = (m_run && e && !done) ? tot : 0;
    end
    m_pos = (m_run && e && !done) ? m_pos + 1 : 0;
    m_run = e;
  endtask

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_all();
    check("dut0.res_valid",   32'(v0), 32'(m_valid[0]));
    check("dut0.res_count",   32'(c0), m_cnt[0]);
    check("dut0.res_overrun", 32'(o0), 32'(m_ovr[0]));
    check("dut0.alarm",       32'(a0), 32'(m_alarm[0]));
    check("dut0.win_active",  32'(w0), 32'(m_run));
    check("dut1.res_valid",   32'(v1), 32'(m_valid[1]));
    check("dut1.res_count",   32'(c1), m_cnt[1]);
    check("dut1.res_overrun", 32'(o1), 32'(m_ovr[1]));
    check("dut1.alarm",       32'(a1), 32'(m_alarm[1]));
    check("dut1.win_active",  32'(w1), 32'(m_run));
  endtask

  task automatic cyc(input bit r, input bit e, input bit h, input bit rd);
    @(negedge clk);
    rst = r; en = e; hit = h; res_ready = rd;
    @(posedge clk);
    model_edge(r, e, h, rd);
    #1;
    check_all();
  endtask

  // Advance with fixed inputs until the model sits at window position tgt.
  task automatic run_to(input int unsigned tgt, input bit h);
    int unsigned n = 0;
    while (m_pos != tgt && n < 4 * WIN) begin
      cyc(1, 1, h, 0);
      n++;
    end
    check("run_to_bound", m_pos, tgt);
  endtask

  initial begin
    rst = 0; en = 0; hit = 0; res_ready = 0;
    // Reset state
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 1);
    check("reset_count", 32'(c0), 0);

    // Three hits in the first window; result 8 cycles after RUN entry
    cyc(1, 1, 0, 0);
    for (int unsigned i = 0; i < WIN; i++) cyc(1, 1, (i == 1 || i == 3 || i == 5), 0);
    check("w1_valid", 32'(v0), 1);
    check("w1_count", 32'(c0), 3);
    check("w1_alarm", 32'(a0), 0);

    // Five hits incl. final cycle; first result consumed on cycle 0
    for (int unsigned i = 0; i < WIN; i++)
      cyc(1, 1, (i == 0 || i == 2 || i == 4 || i == 6 || i == 7), (i == 0));
    check("w2_count", 32'(c0), 5);
    check("w2_alarm", 32'(a0), 1);
    check("w2_sat_count", 32'(c1), 3);

    // Unread across two windows: hit held high, then one hit
    for (int unsigned i = 0; i < WIN; i++) cyc(1, 1, 1, 0);
    check("w3_count", 32'(c0), 8);
    check("w3_sat_count", 32'(c1), 3);
    check("w3_overrun", 32'(o0), 1);
    for (int unsigned i = 0; i < WIN; i++) cyc(1, 1, (i == 2), 0);
    check("w4_count", 32'(c0), 1);
    check("w4_overrun", 32'(o0), 1);
    cyc(1, 1, 0, 1);
    check("hs_valid", 32'(v0), 0);
    check("hs_overrun", 32'(o0), 0);

    // Completion coinciding with handshake
    run_to(0, 0);
    run_to(WIN - 1, 0);
    cyc(1, 1, 1, 1);
    check("coinc_valid", 32'(v0), 1);
    check("coinc_count", 32'(c0), 1);
    check("coinc_overrun", 32'(o0), 0);

    // Drop en at window cycle 5, then re-enter for a full window
    cyc(1, 1, 0, 1);
    run_to(5, 1);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 1, 0);
    for (int unsigned i = 0; i < WIN - 1; i++) cyc(1, 1, (i == 0 || i == 4), 0);
    check("part_no_result", 32'(v0), 0);
    cyc(1, 1, 0, 0);
    check("full_valid", 32'(v0), 1);
    check("full_count", 32'(c0), 2);

    // Reset mid-window
    run_to(3, 1);
    cyc(0, 1, 1, 0);
    check("rst_valid", 32'(v0), 0);
    check("rst_active", 32'(w0), 0);
    check("rst_count1", 32'(c1), 0);

    // Randomized traffic against the model
    for (int unsigned i = 0; i < 3000; i++)
      cyc(($urandom_range(63) != 0), ($urandom_range(15) != 0),
          ($urandom_range(2) == 0), ($urandom_range(3) == 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_hit_window_counter.md
SEQ_HIT_WINDOW_COUNTER -- requirements
Module: seq_hit_window_counter

Interface
REQ-001 SHALL have parameter WIN_LEN, default 64, window length in clk cycles (legal 2..65535).
REQ-002 SHALL have parameter CNT_W, default 8, width of hit count.
REQ-003 SHALL have parameter THRESH, default 4, alarm threshold on windowed hit count.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port en  input  1  window counting enable.
REQ-007 SHALL have port hit  input  1  one-cycle match pulse from the upstream sequence detector (its y output).
REQ-008 SHALL have port res_ready  input  1  consumer accepts result.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_count  output  CNT_W  hits counted in last completed window.
REQ-011 SHALL have port res_overrun  output  1  an unread result was overwritten.
REQ-012 SHALL have port alarm  output  1  last completed window reached THRESH.
REQ-013 SHALL have port win_active  output  1  FSM in RUN.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (en=0) and RUN; IDLE->RUN on en=1, RUN->IDLE on en=0.
REQ-015 SHALL start counting on the first RUN cycle; the window spans exactly WIN_LEN RUN cycles.
REQ-016 SHALL sample hit every RUN cycle and increment the live count, saturating at 2^CNT_W-1.
REQ-017 SHALL, on the edge ending the last window cycle, load res_count with the live count including that cycle's hit, set res_valid=1, and clear the live count.
REQ-018 SHALL restart the next window immediately, with no dead cycle between windows.
REQ-019 SHALL clear res_valid on the edge after a cycle with res_valid=1 and res_ready=1.
REQ-020 SHALL, when a window completes while res_valid=1 and res_ready=0, overwrite res_count and set res_overrun=1.
REQ-021 SHALL, when completion coincides with a handshake, load the new result, keep res_valid=1, and leave res_overrun unchanged.
REQ-022 SHALL hold res_overrun until the next accepted handshake clears it.
REQ-023 SHALL, when en drops mid-window, discard the partial count and window position; a pending result is retained and still handshakeable.
REQ-024 SHALL ignore hit in IDLE.
REQ-025 SHALL set alarm=1 with each result load where count>=THRESH, else 0, with latency identical to res_valid.

Reset
REQ-026 SHALL, while rst=0 at a clock edge, force IDLE, clear live count and window position, and drive res_valid=0, res_count=0, res_overrun=0, alarm=0, win_active=0.
REQ-027 SHALL, on reset asserted mid-window, abort the window with no result produced.

Configuration
REQ-028 SHALL support macro SEQ_HIT_STICKY_ALARM_EN.
REQ-029 SHALL, with SEQ_HIT_STICKY_ALARM_EN defined, hold alarm at 1 once set until rst=0 or the FSM enters IDLE.
REQ-030 SHALL, without SEQ_HIT_STICKY_ALARM_EN, update alarm on every result load per REQ-025.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE=1'b0, RUN=1'b1) and default parameter constants in shared package seq_det_pkg.
REQ-032 SHALL use one sub-module, win_timer, a modulo-WIN_LEN cycle counter with a last-cycle flag; hit counting and result logic stay in the top.

Verification
REQ-033 SHALL cover WIN_LEN=8, en=1, hit pulses on 3 cycles of the first window -> res_valid rises 8 cycles after RUN entry, res_count=3, alarm=0 (THRESH=4).
REQ-034 SHALL cover 5 hits in one window, including a hit on the final cycle -> res_count=5, alarm=1.
REQ-035 SHALL cover res_ready=0 across two windows -> second result overwrites, res_overrun=1; one handshake clears res_valid and res_overrun.
REQ-036 SHALL cover res_ready=1 on the exact completion cycle -> new count loaded, res_valid stays 1, res_overrun=0.
REQ-037 SHALL cover en dropped at window cycle 5, then reasserted -> no result from the partial window, and the next result spans a full 8 cycles.
REQ-038 SHALL cover CNT_W=2 with hit held high for 8 cycles -> res_count=3 (saturated), plus rst=0 mid-window -> all outputs 0 on the next edge.
